resistor_capacitor_high_pass_filter_mac: RTL and testbench

//  First-order RC high-pass filter (series C, shunt R to GND). It mixes SIGNAL_COUNT

---
 rtl/resistor_capacitor_high_pass_filter_mac.sv | 148 ++++++++++++++
 tb/tb_resistor_capacitor_high_pass_filter_mac.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/resistor_capacitor_high_pass_filter_mac.sv
// RC high-pass mixer: the gain-weighted sum of the inputs minus an Euler-integrated capacitor voltage, with one shared multiplier.
// Latency: out_valid comes SIGNAL_COUNT+1 clk after the accepted clk_en; the next strobe is accepted from SIGNAL_COUNT+3 clk.
// No backpressure: a clk_en that arrives while busy is dropped and flagged by a one-cycle overrun pulse.
module resistor_capacitor_high_pass_filter_mac #(
    parameter real SAMPLE_RATE  = 48000.0,
    parameter int  SIGNAL_WIDTH = 16,
    parameter int  SIGNAL_COUNT = 2,
    parameter real C            = 47e-9,
    parameter real R            = 10e3,
    parameter real MIX_GAIN [SIGNAL_COUNT] = '{0.5, 0.5}
) (
    input  logic                                 clk,
    input  logic                                 I_RSTn,
    input  logic                                 clk_en,
    input  logic [SIGNAL_COUNT*SIGNAL_WIDTH-1:0] in,
    output logic [SIGNAL_WIDTH-1:0]              out,
    output logic                                 out_valid,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int W  = SIGNAL_WIDTH;
    localparam int F  = SIGNAL_WIDTH - 1;
    localparam int IW = (SIGNAL_COUNT > 1) ? $clog2(SIGNAL_COUNT) : 1;
    localparam int AW = 2 * SIGNAL_WIDTH + $clog2(SIGNAL_COUNT);
    localparam int VW = SIGNAL_WIDTH + F + 2;
    localparam int DW = SIGNAL_WIDTH + 1;
    localparam int XW = SIGNAL_WIDTH + 3;

    localparam real K_REAL = 1.0 / (SAMPLE_RATE * R * C);
    localparam int  K_Q    = $rtoi(K_REAL * (2.0 ** F) + 0.5);
    localparam logic signed [DW-1:0] K_COEF = DW'(K_Q);

    typedef enum logic [1:0] {S_IDLE, S_MIX, S_DIFF, S_INTEG} state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic signed [W-1:0]     r_in [SIGNAL_COUNT];
    logic signed [AW-1:0]    r_acc;
    logic signed [VW-1:0]    r_vc;
    logic signed [DW-1:0]    r_diff;
    logic signed [W-1:0]     r_out;
    logic                    r_out_valid;
    logic                    r_busy;
    logic                    r_overrun;

    logic signed [DW-1:0]    w_gain [SIGNAL_COUNT];
    logic signed [DW-1:0]    w_gain_sel;
    logic signed [W-1:0]     w_in_sel;
    logic signed [2*W:0]     w_prod;
    logic signed [AW-1:0]    w_acc_next;
    logic signed [AW-1:0]    w_acc_sh;
    logic signed [W-1:0]     w_mix;
    logic signed [W+1:0]     w_vc_int;
    logic signed [XW-1:0]    w_diff_wide;
    logic signed [DW-1:0]    w_diff;
    logic signed [W-1:0]     w_out_sat;
    logic signed [VW-1:0]    w_vc_next;

    for (genvar g = 0; g < SIGNAL_COUNT; g++) begin : g_gain
        localparam int G_Q = $rtoi(MIX_GAIN[g] * (2.0 ** F) + 0.5);
        assign w_gain[g] = DW'(G_Q);
    end

    // One product per MIX cycle; idx selects both the coefficient and the latched sample
    assign w_gain_sel = w_gain[r_idx];
    assign w_in_sel   = r_in[r_idx];
    assign w_prod     = w_gain_sel * w_in_sel;
    assign w_acc_next = r_acc + AW'(w_prod);

    assign w_acc_sh = r_acc >>> F;
    assign w_vc_int = (W+2)'(r_vc >>> F);

    always_comb begin
        w_mix = w_acc_sh[W-1:0];
        if (!((&w_acc_sh[AW-1:W-1]) || (~|w_acc_sh[AW-1:W-1])))
            w_mix = w_acc_sh[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

    assign w_diff_wide = XW'(w_mix) - XW'(w_vc_int);

    always_comb begin
        w_diff = w_diff_wide[DW-1:0];
        if (!((&w_diff_wide[XW-1:DW-1]) || (~|w_diff_wide[XW-1:DW-1])))
            w_diff = w_diff_wide[XW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

    always_comb begin
        w_out_sat = w_diff[W-1:0];
        if (w_diff[DW-1] != w_diff[W-1])
            w_out_sat = w_diff[DW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

    // vc keeps F fraction bits, so K*diff is added without rescaling
    assign w_vc_next = r_vc + VW'(K_COEF * r_diff);

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_vc        <= '0;
            r_diff      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < SIGNAL_COUNT; i++) r_in[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_overrun   <= clk_en && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (clk_en) begin
                        for (int i = 0; i < SIGNAL_COUNT; i++) r_in[i] <= in[i*W +: W];
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MIX;
                    end
                end
                S_MIX: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IW'(SIGNAL_COUNT - 1)) r_state <= S_DIFF;
                end
                S_DIFF: begin
                    r_diff      <= w_diff;
                    r_out       <= w_out_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= S_INTEG;
                end
                S_INTEG: begin
                    r_vc    <= w_vc_next;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_resistor_capacitor_high_pass_filter_mac.sv
// Bench for the RC high-pass mixer: an exact-vector table, a real-valued reference model, and a scoreboard.
module tb_resistor_capacitor_high_pass_filter_mac;

    localparam int W = 16;
    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clk_en = 1'b0;
    logic [N*W-1:0]       in_bus = '0;
    logic signed [W-1:0]  out_s;
    logic                 out_valid;
    logic                 busy;
    logic                 overrun;

    resistor_capacitor_high_pass_filter_mac dut (
        .clk       (clk),
        .I_RSTn    (rst_n),
        .clk_en    (clk_en),
        .in        (in_bus),
        .out       (out_s),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    last_out = 0;
    real   exp_q [$];
    real   tol_q [$];
    int    cyc_q [$];
    string name_q [$];

    real vc_m = 0.0;
    real g_q;
    real k_q;

    task automatic check(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    // Scoreboard: every out_valid consumes the oldest expectation
    always @(negedge clk) begin
        real   e;
        real   t;
        real   d;
        int    c;
        string nm;
        if (out_valid === 1'b1) begin
            last_out = int'(out_s);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_out_valid: got out_valid=1 out=%0d, required no output", last_out);
            end else begin
                e  = exp_q.pop_front();
                t  = tol_q.pop_front();
                c  = cyc_q.pop_front();
                nm = name_q.pop_front();
                d  = real'(last_out) - e;
                if (d < 0.0) d = -d;
                n_tests++;
                if (d > t) begin
                    n_fail++;
                    $display("FAIL %s: got out=%0d, required %0.2f +/- %0.1f", nm, last_out, e, t);
                end
                n_tests++;
                if (cyc != c) begin
                    n_fail++;
                    $display("FAIL %s_latency: got out_valid at cycle %0d, required cycle %0d", nm, cyc, c);
                end
            end
        end
    end

    function automatic real clamp(input real x);
        if (x > 32767.0) return 32767.0;
        if (x < -32768.0) return -32768.0;
        return x;
    endfunction

    task automatic model_step(input int a, input int b, output real o);
        real mix;
        mix  = clamp(g_q * real'(a) + g_q * real'(b));
        o    = clamp(mix - vc_m);
        vc_m = vc_m + k_q * (mix - vc_m);
    endtask

    function automatic logic [N*W-1:0] pack(input int a, input int b);
        logic [W-1:0] a16;
        logic [W-1:0] b16;
        a16 = a[W-1:0];
        b16 = b[W-1:0];
        return {b16, a16};
    endfunction

    // use_model=1: compare against the real model within 2 LSB; else exact value
    task automatic sample(input int a, input int b, input bit use_model, input int exact, input string nm);
        real m;
        model_step(a, b, m);
        @(posedge clk); #1;
        in_bus = pack(a, b);
        clk_en = 1'b1;
        exp_q.push_back(use_model ? m : real'(exact));
        tol_q.push_back(use_model ? 2.0 : 0.0);
        cyc_q.push_back(cyc + N + 2);
        name_q.push_back(nm);
        @(posedge clk); #1;
        clk_en = 1'b0;
        in_bus = $urandom();
        repeat (N + 2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n  = 1'b0;
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vc_m  = 0.0;
    endtask

    typedef struct {
        int    a;
        int    b;
        int    exp;
        string nm;
    } vec_t;

    initial begin
        vec_t tbl [5];
        int   prev;
        int   mono_bad;
        real  m;

        g_q = $floor(0.5 * 32768.0 + 0.5) / 32768.0;
        k_q = $floor(32768.0 / (48000.0 * 47e-9 * 10.0e3) + 0.5) / 32768.0;

        tbl[0] = '{16384, 0, 8192, "step_first"};
        tbl[1] = '{16384, 0, 7829, "step_second"};
        tbl[2] = '{0, 0, -709, "step_to_zero"};
        tbl[3] = '{-16384, 16384, -678, "inputs_cancel"};
        tbl[4] = '{32767, -32768, -649, "truncate_neg"};

        // Reset held with random activity on the inputs
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            in_bus = $urandom();
            clk_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_hold", int'({out_s, out_valid, busy, overrun}), 0);
        end
        @(posedge clk); #1;
        clk_en = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_release_idle", int'({out_s, out_valid, busy, overrun}), 0);
        end

        for (int i = 0; i < 5; i++) sample(tbl[i].a, tbl[i].b, 1'b0, tbl[i].exp, tbl[i].nm);

        // DC step decays monotonically toward zero
        do_reset();
        prev     = 32767;
        mono_bad = 0;
        for (int k = 0; k < 500; k++) begin
            sample(16384, 0, 1'b1, 0, "dc_decay");
            if (last_out > prev) mono_bad++;
            prev = last_out;
        end
        check("dc_monotonic_violations", mono_bad, 0);
        check("dc_settled_within_2", int'(last_out <= 2 && last_out >= -2), 1);

        // Full-scale swing saturates instead of wrapping
        for (int k = 0; k < 300; k++) sample(32767, 32767, 1'b1, 0, "sat_settle");
        sample(-32768, -32768, 1'b0, -32768, "sat_neg_step");

        // Overrun: second back-to-back strobe is dropped
        do_reset();
        model_step(16384, 0, m);
        @(posedge clk); #1;
        in_bus = pack(16384, 0);
        clk_en = 1'b1;
        exp_q.push_back(8192.0);
        tol_q.push_back(0.0);
        cyc_q.push_back(cyc + N + 2);
        name_q.push_back("ovr_single");
        @(posedge clk); #1;
        in_bus = pack(-32768, -32768);
        check("ovr_first_cycle", int'(overrun), 0);
        check("ovr_busy", int'(busy), 1);
        @(posedge clk); #1;
        clk_en = 1'b0;
        check("ovr_pulse", int'(overrun), 1);
        @(posedge clk); #1;
        check("ovr_pulse_end", int'(overrun), 0);
        repeat (N + 3) @(posedge clk);
        sample(16384, 0, 1'b0, 7829, "ovr_next");

        // Reset asserted during MIX clears everything at once
        do_reset();
        sample(16384, 0, 1'b0, 8192, "midop_pre");
        @(posedge clk); #1;
        in_bus = pack(16384, 0);
        clk_en = 1'b1;
        @(posedge clk); #1;
        clk_en = 1'b0;
        check("midop_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midop_out", int'(out_s), 0);
        check("midop_busy", int'(busy), 0);
        check("midop_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vc_m  = 0.0;
        sample(16384, 0, 1'b0, 8192, "midop_cold1");
        sample(16384, 0, 1'b0, 7829, "midop_cold2");

        // Random samples against the real-valued model
        do_reset();
        for (int k = 0; k < 6000; k++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 65535)) - 32768;
            sample(a, b, 1'b1, 0, "random_model");
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
